// File: rtl/btn_debounce_pulse.sv
// btn_debounce_pulse
//
// Per-button input conditioner. Each raw button line passes through a two-flop
// synchroniser and then a counter-based debounce FSM. A new level is accepted
// only after STABLE_CYCLES consecutive identical synchronised samples. On
// acceptance the channel emits a registered one-cycle press or release strobe.
//
// Ports:
//   clk            system clock, rising edge
//   clr            asynchronous, active-high reset
//   btn_raw_i      raw bouncy button inputs, 1 = pressed
//   btn_level_o    debounced level per channel
//   btn_press_o    one-cycle strobe on an accepted 0->1 transition
//   btn_release_o  one-cycle strobe on an accepted 1->0 transition
//   any_press_o    OR of all press strobes, same cycle
module btn_debounce_pulse #(
  parameter int unsigned N_BTN         = 4,
  parameter int unsigned STABLE_CYCLES = 16,
  parameter int unsigned CNT_W         = $clog2(STABLE_CYCLES + 1)
) (
  input  logic             clk,
  input  logic             clr,
  input  logic [N_BTN-1:0] btn_raw_i,
  output logic [N_BTN-1:0] btn_level_o,
  output logic [N_BTN-1:0] btn_press_o,
  output logic [N_BTN-1:0] btn_release_o,
  output logic             any_press_o
);

  typedef enum logic [1:0] {
    StIdleLo,
    StWaitHi,
    StIdleHi,
    StWaitLo
  } state_e;

  // Terminal count: the sample that completes qualification.
  localparam logic [CNT_W-1:0] CntLast = CNT_W'(STABLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CntOne  = CNT_W'(1);

  logic [N_BTN-1:0] sync1_q, sync2_q;

  state_e           state_q [N_BTN];
  state_e           state_d [N_BTN];
  logic [CNT_W-1:0] cnt_q   [N_BTN];
  logic [CNT_W-1:0] cnt_d   [N_BTN];

  logic [N_BTN-1:0] level_q, level_d;
  logic [N_BTN-1:0] press_q, press_d;
  logic [N_BTN-1:0] release_q, release_d;
  logic             any_press_q, any_press_d;

  // Synchroniser, FSM state and registered outputs.
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      sync1_q     <= '0;
      sync2_q     <= '0;
      level_q     <= '0;
      press_q     <= '0;
      release_q   <= '0;
      any_press_q <= 1'b0;
      for (int i = 0; i < int'(N_BTN); i++) begin
        state_q[i] <= StIdleLo;
        cnt_q[i]   <= '0;
      end
    end else begin
      sync1_q     <= btn_raw_i;
      sync2_q     <= sync1_q;
      level_q     <= level_d;
      press_q     <= press_d;
      release_q   <= release_d;
      any_press_q <= any_press_d;
      for (int i = 0; i < int'(N_BTN); i++) begin
        state_q[i] <= state_d[i];
        cnt_q[i]   <= cnt_d[i];
      end
    end
  end

  // Next-state and counter logic, one FSM per channel.
  always_comb begin
    for (int i = 0; i < int'(N_BTN); i++) begin
      state_d[i] = state_q[i];
      cnt_d[i]   = cnt_q[i];
      unique case (state_q[i])
        StIdleLo: begin
          if (sync2_q[i]) begin
            state_d[i] = StWaitHi;
            cnt_d[i]   = CntOne;
          end else begin
            cnt_d[i] = '0;
          end
        end
        StWaitHi: begin
          if (!sync2_q[i]) begin
            state_d[i] = StIdleLo;
            cnt_d[i]   = '0;
          end else if (cnt_q[i] == CntLast) begin
            state_d[i] = StIdleHi;
            cnt_d[i]   = '0;
          end else begin
            cnt_d[i] = cnt_q[i] + CntOne;
          end
        end
        StIdleHi: begin
          if (!sync2_q[i]) begin
            state_d[i] = StWaitLo;
            cnt_d[i]   = CntOne;
          end else begin
            cnt_d[i] = '0;
          end
        end
        StWaitLo: begin
          if (sync2_q[i]) begin
            state_d[i] = StIdleHi;
            cnt_d[i]   = '0;
          end else if (cnt_q[i] == CntLast) begin
            state_d[i] = StIdleLo;
            cnt_d[i]   = '0;
          end else begin
            cnt_d[i] = cnt_q[i] + CntOne;
          end
        end
        default: begin
          state_d[i] = StIdleLo;
          cnt_d[i]   = '0;
        end
      endcase
    end
  end

  // Output decode: strobes fire on the qualifying sample, registered above.
  always_comb begin
    level_d   = '0;
    press_d   = '0;
    release_d = '0;
    for (int i = 0; i < int'(N_BTN); i++) begin
      level_d[i]   = (state_d[i] == StIdleHi) || (state_d[i] == StWaitLo);
      press_d[i]   = (state_q[i] == StWaitHi) && sync2_q[i] && (cnt_q[i] == CntLast);
      release_d[i] = (state_q[i] == StWaitLo) && !sync2_q[i] && (cnt_q[i] == CntLast);
    end
    any_press_d = |press_d;
  end

  assign btn_level_o   = level_q;
  assign btn_press_o   = press_q;
  assign btn_release_o = release_q;
  assign any_press_o   = any_press_q;

endmodule

// File: tb/tb_btn_debounce_pulse.sv
module tb_btn_debounce_pulse;

  localparam int unsigned NB = 4;
  localparam int unsigned SC = 4;

  logic          clk = 1'b0;
  logic          clr = 1'b1;
  logic [NB-1:0] raw = '0;
  logic [NB-1:0] level, press, rel;
  logic          anyp;

  always #5 clk = ~clk;

  btn_debounce_pulse #(
    .N_BTN        (NB),
    .STABLE_CYCLES(SC)
  ) u_dut (
    .clk          (clk),
    .clr          (clr),
    .btn_raw_i    (raw),
    .btn_level_o  (level),
    .btn_press_o  (press),
    .btn_release_o(rel),
    .any_press_o  (anyp)
  );

  int n_vec = 0;
  int n_err = 0;

  // Reference model: two-sample input delay, then a level flips once SC
  // consecutive delayed samples disagree with it.
  logic [NB-1:0] m_d1, m_d2, m_level, m_press, m_rel;
  int            m_run [NB];

  // Observed-output bookkeeping.
  logic [NB-1:0] tff;
  int            press_cnt [NB];
  int            any_cnt;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_d1 = '0; m_d2 = '0; m_level = '0; m_press = '0; m_rel = '0;
    for (int i = 0; i < int'(NB); i++) m_run[i] = 0;
  endtask

  // One clock edge: advance the model, compare all outputs, return at negedge.
  task automatic tick();
    logic [NB-1:0] s;
    @(posedge clk);
    if (clr) begin
      model_reset();
    end else begin
      s = m_d2;
      m_d2 = m_d1;
      m_d1 = raw;
      m_press = '0;
      m_rel = '0;
      for (int i = 0; i < int'(NB); i++) begin
        if (s[i] != m_level[i]) begin
          m_run[i]++;
          if (m_run[i] == int'(SC)) begin
            m_level[i] = s[i];
            m_run[i] = 0;
            if (s[i]) m_press[i] = 1'b1;
            else      m_rel[i] = 1'b1;
          end
        end else begin
          m_run[i] = 0;
        end
      end
    end
    #1;
    check_eq("level", 32'(level), 32'(m_level));
    check_eq("press", 32'(press), 32'(m_press));
    check_eq("release", 32'(rel), 32'(m_rel));
    check_eq("any_press", 32'(anyp), 32'(|m_press));
    tff = tff ^ press;
    for (int i = 0; i < int'(NB); i++) press_cnt[i] += int'(press[i]);
    any_cnt += int'(anyp);
    @(negedge clk);
  endtask

  task automatic ticks(input int n);
    for (int k = 0; k < n; k++) tick();
  endtask

  initial begin
    int   p0;
    int   first;
    logic [NB-1:0] tff0;

    model_reset();
    tff = '0;
    any_cnt = 0;
    for (int i = 0; i < int'(NB); i++) press_cnt[i] = 0;

    // Reset state.
    @(negedge clk);
    tick();
    check_eq("reset_level", 32'(level), 32'h0);
    clr = 1'b0;
    ticks(2);

    // Clean press on channel 0: level/press after the 6th edge (E5).
    raw = 4'b0001;
    for (int k = 1; k <= 8; k++) begin
      tick();
      if (k == 5) check_eq("clean_pre_level", 32'(level[0]), 32'h0);
      if (k == 6) begin
        check_eq("clean_press", 32'(press), 32'h1);
        check_eq("clean_level", 32'(level[0]), 32'h1);
      end
      if (k == 7) check_eq("clean_press_end", 32'(press), 32'h0);
    end

    // Bounce reject on channel 1: runs shorter than SC never qualify.
    p0 = press_cnt[1];
    raw[1] = 1'b1; ticks(3);
    raw[1] = 1'b0; ticks(1);
    raw[1] = 1'b1; ticks(3);
    raw[1] = 1'b0; ticks(8);
    check_eq("bounce_no_press", 32'(press_cnt[1] - p0), 32'h0);
    check_eq("bounce_level", 32'(level[1]), 32'h0);
    raw[1] = 1'b1; ticks(10);
    check_eq("bounce_then_press", 32'(press_cnt[1] - p0), 32'h1);

    // Release on channel 2.
    raw[2] = 1'b1; ticks(10);
    p0 = press_cnt[2];
    raw[2] = 1'b0;
    for (int k = 1; k <= 7; k++) begin
      tick();
      if (k == 6) check_eq("release_pulse", 32'(rel), 32'h4);
      if (k == 7) check_eq("release_end", 32'(rel), 32'h0);
    end
    check_eq("release_level", 32'(level[2]), 32'h0);
    check_eq("release_no_press", 32'(press_cnt[2] - p0), 32'h0);

    // Simultaneous press on all channels.
    raw = '0; ticks(10);
    tff0 = tff;
    p0 = any_cnt;
    raw = 4'b1111; ticks(10);
    check_eq("simul_tff", 32'(tff), 32'(tff0 ^ 4'b1111));
    check_eq("simul_any_cycles", 32'(any_cnt - p0), 32'h1);

    // Reset mid-qualification on channel 3 with the button held.
    raw = '0; ticks(10);
    raw[3] = 1'b1; ticks(4);
    clr = 1'b1;
    #1;
    check_eq("clr_async_level", 32'(level), 32'h0);
    check_eq("clr_async_press", 32'(press), 32'h0);
    p0 = press_cnt[3];
    ticks(3);
    check_eq("clr_no_pulse", 32'(press_cnt[3] - p0), 32'h0);
    clr = 1'b0;
    first = 0;
    for (int k = 1; k <= 20; k++) begin
      tick();
      if (press[3] && first == 0) first = k;
    end
    check_eq("clr_repress_edge", 32'(first), 32'(SC + 2));

    // Long hold on channel 0: a single press, no counter wrap.
    raw = '0; ticks(10);
    p0 = press_cnt[0];
    raw[0] = 1'b1; ticks(1000);
    check_eq("hold_one_press", 32'(press_cnt[0] - p0), 32'h1);
    check_eq("hold_level", 32'(level[0]), 32'h1);

    // Random bouncy traffic with occasional resets.
    for (int k = 0; k < 2000; k++) begin
      for (int i = 0; i < int'(NB); i++)
        if ($urandom_range(7) == 0) raw[i] = ~raw[i];
      if (clr) clr = 1'b0;
      else if ($urandom_range(299) == 0) clr = 1'b1;
      tick();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
